// File: rtl/conv_out_writer_pkg.sv
// Shared definitions for the conv feature-map write-back stage.
// Holds default map geometry, the FSM state type and a counter-width helper.
package conv_out_writer_pkg;

    localparam int DEF_FM_H = 28;
    localparam int DEF_FM_W = 28;
    localparam int DEF_N_CH = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Width of a counter running 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_out_writer_addr_gen.sv
// Channel/column/row counters and multiplier-free address generation for
// planar (ch_base + pix) and channel-interleaved (linear count) layouts.
module conv_out_writer_addr_gen
    import conv_out_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int FM_H       = DEF_FM_H,
    parameter int FM_W       = DEF_FM_W,
    parameter int N_CH       = DEF_N_CH
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  clear,
    input  logic                  step,
    input  logic                  layout,
    output logic [ADDR_WIDTH-1:0] addr_next,
    output logic                  last
);

    localparam int CW = cnt_width(N_CH);
    localparam int XW = cnt_width(FM_W);
    localparam int RW = cnt_width(FM_H);
    localparam logic [ADDR_WIDTH-1:0] PLANE = ADDR_WIDTH'(FM_H * FM_W);

    logic [CW-1:0]         ch_cnt;
    logic [XW-1:0]         col_cnt;
    logic [RW-1:0]         row_cnt;
    logic [ADDR_WIDTH-1:0] pix_cnt;
    logic [ADDR_WIDTH-1:0] ch_base;
    logic [ADDR_WIDTH-1:0] lin_cnt;
    logic                  ch_wrap;
    logic                  col_wrap;
    logic                  row_wrap;

    assign ch_wrap   = (ch_cnt  == CW'(N_CH - 1));
    assign col_wrap  = (col_cnt == XW'(FM_W - 1));
    assign row_wrap  = (row_cnt == RW'(FM_H - 1));
    assign last      = ch_wrap && col_wrap && row_wrap;
    assign addr_next = layout ? lin_cnt : (ch_base + pix_cnt);

    // Channel is the fastest index; pixel/column/row advance only on channel wrap.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            ch_cnt  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            pix_cnt <= '0;
            ch_base <= '0;
            lin_cnt <= '0;
        end else if (clear) begin
            ch_cnt  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            pix_cnt <= '0;
            ch_base <= '0;
            lin_cnt <= '0;
        end else if (step) begin
            lin_cnt <= last ? '0 : lin_cnt + ADDR_WIDTH'(1);
            if (!ch_wrap) begin
                ch_cnt  <= ch_cnt + CW'(1);
                ch_base <= ch_base + PLANE;
            end else begin
                ch_cnt  <= '0;
                ch_base <= '0;
                pix_cnt <= last ? '0 : pix_cnt + ADDR_WIDTH'(1);
                if (!col_wrap) begin
                    col_cnt <= col_cnt + XW'(1);
                end else begin
                    col_cnt <= '0;
                    row_cnt <= row_wrap ? '0 : row_cnt + RW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/conv_out_writer.sv
// Conv feature-map write-back: frames a serial result stream, applies optional
// ReLU and drives BRAM port A writes with one cycle of latency.
module conv_out_writer
    import conv_out_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int FM_H       = DEF_FM_H,
    parameter int FM_W       = DEF_FM_W,
    parameter int N_CH       = DEF_N_CH
) (
    input  logic                         iclk,
    input  logic                         irst,
    input  logic                         start,
    input  logic                         layout,
    input  logic                         relu_en,
    input  logic signed [DATA_WIDTH-1:0] y,
    input  logic                         valid,
    output logic                         ena,
    output logic                         wea,
    output logic        [ADDR_WIDTH-1:0] addr,
    output logic signed [DATA_WIDTH-1:0] dout,
    output logic                         busy,
    output logic                         done,
    output logic                         err_drop
);

    state_t                       state;
    state_t                       state_next;
    logic                         layout_r;
    logic                         relu_r;
    logic                         start_acc;
    logic                         accept;
    logic                         last;
    logic        [ADDR_WIDTH-1:0] addr_next;
    logic signed [DATA_WIDTH-1:0] y_relu;

    assign start_acc = (state == ST_IDLE) && start;
    assign accept    = (state == ST_RUN) && valid;
    assign y_relu    = (relu_r && y[DATA_WIDTH-1]) ? '0 : y;
    assign busy      = (state == ST_RUN);

    conv_out_writer_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .FM_H       (FM_H),
        .FM_W       (FM_W),
        .N_CH       (N_CH)
    ) u_addr_gen (
        .iclk      (iclk),
        .irst      (irst),
        .clear     (start_acc),
        .step      (accept),
        .layout    (layout_r),
        .addr_next (addr_next),
        .last      (last)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)          state_next = ST_RUN;
            ST_RUN:  if (accept && last) state_next = ST_IDLE;
            default:                     state_next = ST_IDLE;
        endcase
    end

    // Frame control plus the registered BRAM write port; addr holds between writes.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state    <= ST_IDLE;
            layout_r <= 1'b0;
            relu_r   <= 1'b0;
            ena      <= 1'b0;
            wea      <= 1'b0;
            addr     <= '0;
            dout     <= '0;
            done     <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            state <= state_next;
            if (start_acc) begin
                layout_r <= layout;
                relu_r   <= relu_en;
            end
            ena  <= accept;
            wea  <= accept;
            dout <= accept ? y_relu : '0;
            done <= accept && last;
            if (accept) addr <= addr_next;
            if ((state == ST_IDLE) && valid) err_drop <= 1'b1;
            else if (start_acc)              err_drop <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_out_writer.sv
// Self-checking bench for conv_out_writer on a 2x3x2 map (12 samples per frame);
// a scoreboard queue is filled as samples are accepted and drained on each write.
module tb_conv_out_writer;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          iclk = 1'b0;
    logic          irst;
    logic          start;
    logic          layout;
    logic          relu_en;
    logic [DW-1:0] y;
    logic          valid;
    logic          ena;
    logic          wea;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic          busy;
    logic          done;
    logic          err_drop;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   m_run = 0;
    int   m_k = 0;
    bit   m_layout = 0;
    bit   m_relu = 0;
    int   cnt;
    logic [DW-1:0] relu_ys [12] = '{16'hFFFB, 16'd7, 16'h8000, 16'd0, 16'hFFFF, 16'd1,
                                    16'h7FFF, 16'hFF9C, 16'd5, 16'd6, 16'hFFF9, 16'd9};

    conv_out_writer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FM_H       (2),
        .FM_W       (3),
        .N_CH       (2)
    ) dut (
        .iclk     (iclk),
        .irst     (irst),
        .start    (start),
        .layout   (layout),
        .relu_en  (relu_en),
        .y        (y),
        .valid    (valid),
        .ena      (ena),
        .wea      (wea),
        .addr     (addr),
        .dout     (dout),
        .busy     (busy),
        .done     (done),
        .err_drop (err_drop)
    );

    always #5 iclk = ~iclk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle; the model decides acceptance from its pre-edge state.
    task automatic apply_stimulus(input bit s, input bit v, input logic [DW-1:0] yv,
                                  input bit lay, input bit rel);
        exp_t e;
        int   pix;
        int   ch;
        start   = s;
        valid   = v;
        y       = yv;
        layout  = lay;
        relu_en = rel;
        @(posedge iclk);
        if (v && m_run) begin
            pix    = m_k / 2;
            ch     = m_k % 2;
            e.addr = m_layout ? 4'(pix * 2 + ch) : 4'(ch * 6 + pix);
            e.data = (m_relu && $signed(yv) < 0) ? 16'd0 : yv;
            e.last = (m_k == 11);
            sb.push_back(e);
            m_k++;
            if (m_k == 12) begin
                m_run = 0;
                m_k   = 0;
            end
        end else if (s && !m_run) begin
            m_run    = 1;
            m_k      = 0;
            m_layout = lay;
            m_relu   = rel;
        end
        #1;
        start = 1'b0;
        valid = 1'b0;
        y     = '0;
    endtask

    always @(negedge iclk) begin
        if (irst) begin
            check_output("wea_vs_sb", {31'b0, wea}, {31'b0, sb.size() != 0});
            if (wea && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check_output("addr", {28'b0, addr}, {28'b0, e.addr});
                check_output("dout", {16'b0, dout}, {16'b0, e.data});
                check_output("done", {31'b0, done}, {31'b0, e.last});
                check_output("busy_w", {31'b0, busy}, {31'b0, !e.last});
                check_output("ena_w", {31'b0, ena}, 32'd1);
            end else if (!wea) begin
                check_output("idle_dout", {16'b0, dout}, 32'd0);
                check_output("idle_done", {31'b0, done}, 32'd0);
                check_output("idle_ena", {31'b0, ena}, 32'd0);
            end
        end
    end

    initial begin
        irst = 1'b0; start = 1'b0; layout = 1'b0; relu_en = 1'b0; y = '0; valid = 1'b0;
        #12;
        check_output("rst_ena", {31'b0, ena}, 32'd0);
        check_output("rst_wea", {31'b0, wea}, 32'd0);
        check_output("rst_addr", {28'b0, addr}, 32'd0);
        check_output("rst_dout", {16'b0, dout}, 32'd0);
        check_output("rst_busy", {31'b0, busy}, 32'd0);
        check_output("rst_done", {31'b0, done}, 32'd0);
        check_output("rst_err", {31'b0, err_drop}, 32'd0);
        @(negedge iclk);
        irst = 1'b1;
        @(posedge iclk);
        #1;

        // Valid while idle is dropped and flagged; start clears the flag.
        apply_stimulus(0, 1, 16'd3, 0, 0);
        check_output("err_set", {31'b0, err_drop}, 32'd1);
        apply_stimulus(0, 0, 16'd0, 0, 0);
        check_output("err_sticky", {31'b0, err_drop}, 32'd1);
        apply_stimulus(1, 0, 16'd0, 0, 0);
        check_output("err_clr", {31'b0, err_drop}, 32'd0);
        check_output("busy_start", {31'b0, busy}, 32'd1);

        // Planar, back-to-back.
        for (int i = 0; i < 12; i++) apply_stimulus(0, 1, 16'(i), 0, 0);
        check_output("busy_end_planar", {31'b0, busy}, 32'd0);
        apply_stimulus(0, 0, 16'd0, 0, 0);

        // Interleaved with a gap every third cycle.
        apply_stimulus(1, 0, 16'd0, 1, 0);
        cnt = 0;
        for (int c = 0; cnt < 12; c++) begin
            if (c % 3 == 2) apply_stimulus(0, 0, 16'd0, 1, 0);
            else begin
                apply_stimulus(0, 1, 16'(100 + cnt), 1, 0);
                cnt++;
            end
        end
        apply_stimulus(0, 0, 16'd0, 0, 0);

        // ReLU on (planar, layout pin toggled mid-frame), then ReLU off back-to-back.
        apply_stimulus(1, 0, 16'd0, 0, 1);
        for (int i = 0; i < 12; i++) apply_stimulus(0, 1, relu_ys[i], 1, 0);
        apply_stimulus(1, 0, 16'd0, 1, 0);
        for (int i = 0; i < 12; i++) apply_stimulus(0, 1, relu_ys[i], 0, 1);
        check_output("busy_end_relu", {31'b0, busy}, 32'd0);
        apply_stimulus(0, 0, 16'd0, 0, 0);

        // Start mid-frame and with the last sample are both ignored.
        apply_stimulus(1, 0, 16'd0, 0, 0);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 16'(200 + i), 0, 0);
        apply_stimulus(1, 1, 16'd204, 1, 1);
        for (int i = 5; i < 11; i++) apply_stimulus(0, 1, 16'(200 + i), 0, 0);
        apply_stimulus(1, 1, 16'd211, 1, 0);
        check_output("busy_after_overlap", {31'b0, busy}, 32'd0);
        apply_stimulus(0, 1, 16'd55, 0, 0);
        check_output("err_after_ignored_start", {31'b0, err_drop}, 32'd1);
        check_output("busy_still_idle", {31'b0, busy}, 32'd0);

        // Reset mid-frame abandons the frame.
        apply_stimulus(1, 0, 16'd0, 0, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(0, 1, 16'(300 + i), 0, 0);
        @(negedge iclk);
        #1;
        irst = 1'b0;
        m_run = 0;
        m_k = 0;
        #1;
        check_output("mid_rst_ena", {31'b0, ena}, 32'd0);
        check_output("mid_rst_wea", {31'b0, wea}, 32'd0);
        check_output("mid_rst_addr", {28'b0, addr}, 32'd0);
        check_output("mid_rst_dout", {16'b0, dout}, 32'd0);
        check_output("mid_rst_busy", {31'b0, busy}, 32'd0);
        check_output("mid_rst_done", {31'b0, done}, 32'd0);
        #10;
        @(negedge iclk);
        irst = 1'b1;
        @(posedge iclk);
        #1;
        apply_stimulus(1, 0, 16'd0, 1, 0);
        for (int i = 0; i < 12; i++) apply_stimulus(0, 1, 16'(400 + i), 1, 0);
        apply_stimulus(0, 0, 16'd0, 0, 0);
        apply_stimulus(0, 0, 16'd0, 0, 0);

        check_output("sb_drain", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
